// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter and its prescaler.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Prescaler phase width; never narrower than one bit so PRESCALE==1 still elaborates.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; STEP marks the enabled cycle that completes a period.
import counter_pkg::*;

module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CLRP,
  input  logic EN,
  output logic STEP
);

  localparam int PW = clog2_min1(PRESCALE);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE must be >= 1");
    end

    if (PRESCALE == 1) begin : g_bypass
      assign STEP = EN;
    end else begin : g_divide
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase_q;
      logic [PW-1:0] phase_d;

      assign STEP = EN && (phase_q == LAST);

      // Phase only advances on enabled cycles, so EN low stretches the period exactly.
      always_comb begin
        phase_d = phase_q;
        if (CLRP)      phase_d = '0;
        else if (STEP) phase_d = '0;
        else if (EN)   phase_d = phase_q + PW'(1);
      end

      always_ff @(posedge CLK) begin
        if (CLR) phase_q <= '0;
        else     phase_q <= phase_d;
      end
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with prescale, load, wrap pulse and sticky overflow.
import counter_pkg::*;

module mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             OVF
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("mod_counter: WIDTH must be >= 1");
    end
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
      $error("mod_counter: RESET_VAL must be < MODULUS");
    end
  endgenerate

  // Held as a WIDTH-bit constant so MODULUS == 2**WIDTH needs no extra bit.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_max;
  logic             at_zero;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .CLK (CLK),
    .CLR (CLR),
    .CLRP(LD),
    .EN  (EN),
    .STEP(step)
  );

  assign at_max  = (q_q == MAX_Q);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d   = q_q;
    co_d  = 1'b0;
    ovf_d = ovf_q;
    if (LD) begin
      q_d   = (D > MAX_Q) ? MAX_Q : D;
      ovf_d = 1'b0;
    end else if (step) begin
      if (UP == CNT_UP) begin
        if (at_max) begin
          q_d   = '0;
          co_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_d   = MAX_Q;
          co_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_q   <= RST_Q;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign CO  = co_q;
  assign OVF = ovf_q;
  assign TC  = (UP == CNT_UP) ? at_max : at_zero;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter across three parameter sets sharing one clock.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: MODULUS=10 PRESCALE=1; u1: MODULUS=10 PRESCALE=3; u2: MODULUS=16 RESET_VAL=3
  logic       clr0 = 1'b1, en0 = 1'b0, up0 = 1'b1, ld0 = 1'b0;
  logic [3:0] d0 = 4'd0, q0;
  logic       tc0, co0, ovf0;
  logic       clr1 = 1'b1, en1 = 1'b0, up1 = 1'b1, ld1 = 1'b0;
  logic [3:0] d1 = 4'd0, q1;
  logic       tc1, co1, ovf1;
  logic       clr2 = 1'b1, en2 = 1'b0, up2 = 1'b1, ld2 = 1'b0;
  logic [3:0] d2 = 4'd0, q2;
  logic       tc2, co2, ovf2;

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RESET_VAL(0)) u0 (
    .CLK(clk), .CLR(clr0), .EN(en0), .UP(up0), .LD(ld0), .D(d0),
    .Q(q0), .TC(tc0), .CO(co0), .OVF(ovf0));

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .RESET_VAL(0)) u1 (
    .CLK(clk), .CLR(clr1), .EN(en1), .UP(up1), .LD(ld1), .D(d1),
    .Q(q1), .TC(tc1), .CO(co1), .OVF(ovf1));

  mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .RESET_VAL(3)) u2 (
    .CLK(clk), .CLR(clr2), .EN(en2), .UP(up2), .LD(ld2), .D(d2),
    .Q(q2), .TC(tc2), .CO(co2), .OVF(ovf2));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (q0 !== 4'd0 || co0 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got Q=%0d CO=%b OVF=%b want Q=0 CO=0 OVF=0", q0, co0, ovf0);
    end
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    en0 = 1'b1; up0 = 1'b1;
    repeat (7) tick();
    checks++;
    if (q0 !== 4'd7) begin
      errors++;
      $display("FAIL reset_count7: got Q=%0d want 7", q0);
    end
    clr0 = 1'b1;
    tick();
    checks++;
    if (q0 !== 4'd0 || co0 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcount: got Q=%0d CO=%b OVF=%b want Q=0 CO=0 OVF=0", q0, co0, ovf0);
    end
    clr0 = 1'b0; en0 = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q;
    logic       exp_co;
    en0 = 1'b1; up0 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_q  = 4'(i % 10);
      exp_co = (i == 10);
      checks++;
      if (q0 !== exp_q || co0 !== exp_co || ovf0 !== exp_co || tc0 !== (exp_q == 4'd9)) begin
        errors++;
        $display("FAIL count_up_%0d: got Q=%0d CO=%b OVF=%b TC=%b want Q=%0d CO=%b OVF=%b TC=%b",
                 i, q0, co0, ovf0, tc0, exp_q, exp_co, exp_co, (exp_q == 4'd9));
      end
    end
    en0 = 1'b0;
    tick();
    checks++;
    if (q0 !== 4'd0 || co0 !== 1'b0 || ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL count_up_sticky: got Q=%0d CO=%b OVF=%b want Q=0 CO=0 OVF=1", q0, co0, ovf0);
    end
    $display("test_count_up done");
  endtask

  task automatic test_count_down();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0; up0 = 1'b0;
    #1;
    checks++;
    if (tc0 !== 1'b1) begin
      errors++;
      $display("FAIL down_tc_at0: got TC=%b want 1", tc0);
    end
    en0 = 1'b1;
    tick();
    checks++;
    if (q0 !== 4'd9 || co0 !== 1'b1 || ovf0 !== 1'b1 || tc0 !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap: got Q=%0d CO=%b OVF=%b TC=%b want Q=9 CO=1 OVF=1 TC=0", q0, co0, ovf0, tc0);
    end
    tick();
    checks++;
    if (q0 !== 4'd8 || co0 !== 1'b0 || ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL down_next: got Q=%0d CO=%b OVF=%b want Q=8 CO=0 OVF=1", q0, co0, ovf0);
    end
    en0 = 1'b0;
    $display("test_count_down done");
  endtask

  task automatic test_load();
    ld0 = 1'b1; d0 = 4'd5;
    tick();
    checks++;
    if (q0 !== 4'd5 || ovf0 !== 1'b0 || co0 !== 1'b0) begin
      errors++;
      $display("FAIL load_5: got Q=%0d OVF=%b CO=%b want Q=5 OVF=0 CO=0", q0, ovf0, co0);
    end
    d0 = 4'd12;
    tick();
    checks++;
    if (q0 !== 4'd9) begin
      errors++;
      $display("FAIL load_clamp: got Q=%0d want 9", q0);
    end
    d0 = 4'd3; en0 = 1'b1; up0 = 1'b1;
    tick();
    checks++;
    if (q0 !== 4'd3) begin
      errors++;
      $display("FAIL load_over_en: got Q=%0d want 3", q0);
    end
    d0 = 4'd9; ld0 = 1'b1;
    tick();
    ld0 = 1'b0;
    tick();
    checks++;
    if (q0 !== 4'd0 || co0 !== 1'b1 || ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL load_then_wrap: got Q=%0d CO=%b OVF=%b want Q=0 CO=1 OVF=1", q0, co0, ovf0);
    end
    ld0 = 1'b1; d0 = 4'd2;
    tick();
    checks++;
    if (q0 !== 4'd2 || ovf0 !== 1'b0 || co0 !== 1'b0) begin
      errors++;
      $display("FAIL load_clears_ovf: got Q=%0d OVF=%b CO=%b want Q=2 OVF=0 CO=0", q0, ovf0, co0);
    end
    clr0 = 1'b1; d0 = 4'd6;
    tick();
    checks++;
    if (q0 !== 4'd0) begin
      errors++;
      $display("FAIL clr_over_load: got Q=%0d want 0", q0);
    end
    clr0 = 1'b0; ld0 = 1'b0; en0 = 1'b0;
    $display("test_load done");
  endtask

  task automatic test_prescale();
    logic [3:0] exp_run [6]   = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    logic [3:0] exp_stall [5] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    logic       en_stall [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_ld [4]    = '{4'd7, 4'd7, 4'd7, 4'd8};
    en1 = 1'b1; up1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (q1 !== exp_run[i]) begin
        errors++;
        $display("FAIL prescale_run_%0d: got Q=%0d want %0d", i, q1, exp_run[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      en1 = en_stall[i];
      tick();
      checks++;
      if (q1 !== exp_stall[i]) begin
        errors++;
        $display("FAIL prescale_stall_%0d: got Q=%0d want %0d", i, q1, exp_stall[i]);
      end
    end
    en1 = 1'b1;
    tick();
    ld1 = 1'b1; d1 = 4'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      ld1 = 1'b0;
      checks++;
      if (q1 !== exp_ld[i]) begin
        errors++;
        $display("FAIL prescale_load_%0d: got Q=%0d want %0d", i, q1, exp_ld[i]);
      end
    end
    en1 = 1'b0;
    $display("test_prescale done");
  endtask

  task automatic test_alt_reset();
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    checks++;
    if (q2 !== 4'd3 || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL alt_reset: got Q=%0d OVF=%b want Q=3 OVF=0", q2, ovf2);
    end
    ld2 = 1'b1; d2 = 4'd15;
    tick();
    ld2 = 1'b0; up2 = 1'b1;
    #1;
    checks++;
    if (q2 !== 4'd15 || tc2 !== 1'b1) begin
      errors++;
      $display("FAIL alt_tc15: got Q=%0d TC=%b want Q=15 TC=1", q2, tc2);
    end
    en2 = 1'b1;
    tick();
    checks++;
    if (q2 !== 4'd0 || co2 !== 1'b1 || ovf2 !== 1'b1) begin
      errors++;
      $display("FAIL alt_up_wrap: got Q=%0d CO=%b OVF=%b want Q=0 CO=1 OVF=1", q2, co2, ovf2);
    end
    up2 = 1'b0;
    #1;
    checks++;
    if (tc2 !== 1'b1) begin
      errors++;
      $display("FAIL alt_tc0_down: got TC=%b want 1", tc2);
    end
    tick();
    checks++;
    if (q2 !== 4'd15 || co2 !== 1'b1) begin
      errors++;
      $display("FAIL alt_down_wrap: got Q=%0d CO=%b want Q=15 CO=1", q2, co2);
    end
    tick();
    checks++;
    if (q2 !== 4'd14 || co2 !== 1'b0) begin
      errors++;
      $display("FAIL alt_down_next: got Q=%0d CO=%b want Q=14 CO=0", q2, co2);
    end
    en2 = 1'b0;
    $display("test_alt_reset done");
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_prescale();
    test_alt_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
